// File: rtl/wts_timer_pkg.sv
// Shared definitions for the wts_timer_gen interval generator: channel FSM
// encodings and the width of the per-channel expiry index.
package wts_timer_pkg;

  localparam int ADDR_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/wts_timer_gen_if.sv
// Register-side configuration and trigger outputs of wts_timer_gen.
// master = register/interrupt side, slave = the timer generator.
interface wts_timer_gen_if #(
  parameter int CNT_W = 12
);
  import wts_timer_pkg::*;

  logic [CNT_W-1:0]  reg_timer1_period;
  logic              reg_timer1_run;
  logic              reg_timer1_oneshot;
  logic              timer1_trigger;
  logic [ADDR_W-1:0] timer1_address;

  logic [CNT_W-1:0]  reg_timer2_period;
  logic              reg_timer2_run;
  logic              reg_timer2_oneshot;
  logic              timer2_trigger;
  logic [ADDR_W-1:0] timer2_address;

  modport master (
    output reg_timer1_period, reg_timer1_run, reg_timer1_oneshot,
    output reg_timer2_period, reg_timer2_run, reg_timer2_oneshot,
    input  timer1_trigger, timer1_address,
    input  timer2_trigger, timer2_address
  );

  modport slave (
    input  reg_timer1_period, reg_timer1_run, reg_timer1_oneshot,
    input  reg_timer2_period, reg_timer2_run, reg_timer2_oneshot,
    output timer1_trigger, timer1_address,
    output timer2_trigger, timer2_address
  );

endinterface

// File: rtl/wts_timer_channel.sv
// One interval channel: IDLE/RUN/DONE FSM, reloadable down-counter,
// registered 1-clk expiry pulse and 2-bit wrapping expiry index.
module wts_timer_channel
  import wts_timer_pkg::*;
#(
  parameter int CNT_W = 12
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              tick,
  input  logic              run,
  input  logic              oneshot,
  input  logic [CNT_W-1:0]  period,
  output logic              trigger,
  output logic [ADDR_W-1:0] address
);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ADDR_W-1:0] address_nxt;
  logic              expire;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    address_nxt = address;
    expire      = 1'b0;
    // The index advances on the edge that ends the pulse, so it reads the
    // pre-increment value while trigger is high.
    if (trigger) address_nxt = address + ADDR_W'(1);
    unique case (state)
      ST_IDLE: begin
        if (run) begin
          state_nxt   = ST_RUN;
          cnt_nxt     = period;
          address_nxt = '0;
        end
      end
      ST_RUN: begin
        if (!run) begin
          state_nxt = ST_IDLE;
        end else if (tick) begin
          if (cnt != '0) begin
            cnt_nxt = cnt - CNT_W'(1);
          end else begin
            expire  = 1'b1;
            cnt_nxt = period;
            if (oneshot) state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (!run) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      address <= '0;
      trigger <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      address <= address_nxt;
      trigger <= expire;
    end
  end

endmodule

// File: rtl/wts_timer_gen.sv
// Periodic/one-shot interval generator: shared prescaler plus two channels.
// Define WTS_TIMER_CASCADE_EN to clock channel 2 from channel 1 expiries.
module wts_timer_gen
  import wts_timer_pkg::*;
#(
  parameter int CLK_DIV = 16,
  parameter int CNT_W   = 12
) (
  input logic           clk,
  input logic           nreset,
  wts_timer_gen_if.slave bus
);

  localparam int PS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PS_W-1:0] ps_cnt;
  logic            tick;
  logic            tick2;

  assign tick = (ps_cnt == PS_W'(CLK_DIV - 1));

  // Free-running; run requests never stall it, so entry phase is arbitrary.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)   ps_cnt <= '0;
    else if (tick) ps_cnt <= '0;
    else           ps_cnt <= ps_cnt + PS_W'(1);
  end

`ifdef WTS_TIMER_CASCADE_EN
  assign tick2 = bus.timer1_trigger;
`else
  assign tick2 = tick;
`endif

  wts_timer_channel #(.CNT_W(CNT_W)) u_ch1 (
    .clk     (clk),
    .nreset  (nreset),
    .tick    (tick),
    .run     (bus.reg_timer1_run),
    .oneshot (bus.reg_timer1_oneshot),
    .period  (bus.reg_timer1_period),
    .trigger (bus.timer1_trigger),
    .address (bus.timer1_address)
  );

  wts_timer_channel #(.CNT_W(CNT_W)) u_ch2 (
    .clk     (clk),
    .nreset  (nreset),
    .tick    (tick2),
    .run     (bus.reg_timer2_run),
    .oneshot (bus.reg_timer2_oneshot),
    .period  (bus.reg_timer2_period),
    .trigger (bus.timer2_trigger),
    .address (bus.timer2_address)
  );

endmodule

// File: tb/tb_wts_timer_gen.sv
// Directed bench for wts_timer_gen (CLK_DIV=4, CNT_W=12): table of channel-1
// run vectors plus hand sequences for period change, coincidence and reset.
module tb_wts_timer_gen;

  localparam int CLK_DIV = 4;
  localparam int CNT_W   = 12;

  logic clk;
  logic nreset;
  int   cyc;
  int   tests;
  int   fails;

  int   t1c[$];
  int   t1a[$];
  int   t2c[$];
  int   t2a[$];
  int   consec1;
  int   consec2;
  bit   prev1;
  bit   prev2;

  wts_timer_gen_if #(.CNT_W(CNT_W)) bus ();

  wts_timer_gen #(.CLK_DIV(CLK_DIV), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every pulse away from the active edge.
  initial begin
    consec1 = 0; consec2 = 0; prev1 = 1'b0; prev2 = 1'b0;
  end
  always @(negedge clk) begin
    if (bus.timer1_trigger) begin
      t1c.push_back(cyc);
      t1a.push_back(int'(bus.timer1_address));
      if (prev1) consec1 = consec1 + 1;
    end
    if (bus.timer2_trigger) begin
      t2c.push_back(cyc);
      t2a.push_back(int'(bus.timer2_address));
      if (prev2) consec2 = consec2 + 1;
    end
    prev1 = bus.timer1_trigger;
    prev2 = bus.timer2_trigger;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic until_cyc(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic wait_q1(input int target, input int budget, output bit ok);
    int n = 0;
    while (t1c.size() < target && n < budget) begin
      step(1);
      n++;
    end
    ok = (t1c.size() >= target);
  endtask

  typedef struct {
    int p;
    bit os;
    int n;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int  k, w, b1, b2, got, ival, e;
    bit  ok;

    vecs[0] = '{p: 2, os: 1'b0, n: 5};
    vecs[1] = '{p: 0, os: 1'b1, n: 1};
    vecs[2] = '{p: 0, os: 1'b0, n: 6};
    vecs[3] = '{p: 3, os: 1'b0, n: 3};
    vecs[4] = '{p: 1, os: 1'b1, n: 1};
    vecs[5] = '{p: 7, os: 1'b0, n: 2};

    tests = 0; fails = 0;
    nreset = 1'b0;
    bus.reg_timer1_period = '0; bus.reg_timer1_run = 1'b0; bus.reg_timer1_oneshot = 1'b0;
    bus.reg_timer2_period = '0; bus.reg_timer2_run = 1'b0; bus.reg_timer2_oneshot = 1'b0;
    step(3);
    check("reset_trig1", int'(bus.timer1_trigger), 0);
    check("reset_addr1", int'(bus.timer1_address), 0);
    check("reset_trig2", int'(bus.timer2_trigger), 0);
    check("reset_addr2", int'(bus.timer2_address), 0);
    nreset = 1'b1;
    step(20);
    check("idle_no_pulse1", t1c.size(), 0);
    check("idle_no_pulse2", t2c.size(), 0);

    // Table: one run window per vector on channel 1, channel 2 left idle.
    for (int v = 0; v < 6; v++) begin
      ival = 4 * (vecs[v].p + 1);
      w = vecs[v].os ? (5 + 4 * vecs[v].p + 3 * ival)
                     : (5 + 4 * vecs[v].p + ival * (vecs[v].n - 1));
      bus.reg_timer1_period  = CNT_W'(vecs[v].p);
      bus.reg_timer1_oneshot = vecs[v].os;
      b1 = t1c.size(); b2 = t2c.size();
      bus.reg_timer1_run = 1'b1;
      k = cyc;
      until_cyc(k + w);
      bus.reg_timer1_run = 1'b0;
      step(4);
      got = t1c.size() - b1;
      check($sformatf("v%0d_count", v), got, vecs[v].n);
      check($sformatf("v%0d_ch2_quiet", v), t2c.size() - b2, 0);
      if (got > 0)
        check_range($sformatf("v%0d_latency", v), t1c[b1] - (k + 1),
                    4 * vecs[v].p + 1, 4 * vecs[v].p + 4);
      for (int i = 0; i < got && i < vecs[v].n; i++) begin
        check($sformatf("v%0d_addr%0d", v, i), t1a[b1 + i], i % 4);
        if (i > 0)
          check($sformatf("v%0d_ival%0d", v, i), t1c[b1 + i] - t1c[b1 + i - 1], ival);
      end
    end

    // One-shot holds in DONE while run stays high; re-arm restarts index at 0.
    bus.reg_timer1_period = '0; bus.reg_timer1_oneshot = 1'b1;
    b1 = t1c.size();
    bus.reg_timer1_run = 1'b1;
    step(40);
    check("os_single", t1c.size() - b1, 1);
    bus.reg_timer1_run = 1'b0;
    step(2);
    bus.reg_timer1_run = 1'b1;
    step(10);
    check("os_rearm_count", t1c.size() - b1, 2);
    if (t1c.size() - b1 == 2) check("os_rearm_addr", t1a[b1 + 1], 0);
    bus.reg_timer1_run = 1'b0;
    step(4);

    // Period change mid-interval applies at the next reload only.
    bus.reg_timer1_period = 12'd5; bus.reg_timer1_oneshot = 1'b0;
    b1 = t1c.size();
    bus.reg_timer1_run = 1'b1;
    wait_q1(b1 + 1, 60, ok);
    check("pchg_first", int'(ok), 1);
    step(8);
    bus.reg_timer1_period = 12'd1;
    wait_q1(b1 + 4, 80, ok);
    check("pchg_pulses", int'(ok), 1);
    if (ok) begin
      check("pchg_ival_cur", t1c[b1 + 1] - t1c[b1], 24);
      check("pchg_ival_new", t1c[b1 + 2] - t1c[b1 + 1], 8);
      check("pchg_ival_new2", t1c[b1 + 3] - t1c[b1 + 2], 8);
    end
    bus.reg_timer1_run = 1'b0;
    step(4);

`ifndef WTS_TIMER_CASCADE_EN
    // Both channels started together coincide; run2 dropped at the expiry tick.
    bus.reg_timer1_period = 12'd3; bus.reg_timer2_period = 12'd3;
    bus.reg_timer1_oneshot = 1'b0; bus.reg_timer2_oneshot = 1'b0;
    b1 = t1c.size(); b2 = t2c.size();
    bus.reg_timer1_run = 1'b1; bus.reg_timer2_run = 1'b1;
    wait_q1(b1 + 3, 80, ok);
    check("both_pulses", int'(ok), 1);
    if (ok) begin
      check("both_ch2_count", t2c.size() - b2, 3);
      for (int i = 0; i < 3 && i < t2c.size() - b2; i++) begin
        check($sformatf("both_coincide%0d", i), t2c[b2 + i], t1c[b1 + i]);
        check($sformatf("both_addr2_%0d", i), t2a[b2 + i], i);
      end
      check("both_ival", t1c[b1 + 2] - t1c[b1 + 1], 16);
      e = t1c[b1 + 2];
      until_cyc(e + 15);
      bus.reg_timer2_run = 1'b0;
      step(5);
      check("drop_ch1_pulse", t1c.size() - b1, 4);
      if (t1c.size() - b1 >= 4) check("drop_ch1_time", t1c[b1 + 3], e + 16);
      check("drop_ch2_none", t2c.size() - b2, 3);
    end
    bus.reg_timer1_run = 1'b0; bus.reg_timer2_run = 1'b0;
    step(4);
`else
    // Cascade: ch2 counts ch1 expiries and pulses one clk after every 2nd one.
    bus.reg_timer1_period = 12'd0; bus.reg_timer2_period = 12'd1;
    bus.reg_timer1_oneshot = 1'b0; bus.reg_timer2_oneshot = 1'b0;
    b1 = t1c.size(); b2 = t2c.size();
    bus.reg_timer1_run = 1'b1; bus.reg_timer2_run = 1'b1;
    wait_q1(b1 + 6, 80, ok);
    step(2);
    check("casc_ch1", int'(ok), 1);
    check("casc_ch2_count", t2c.size() - b2, 3);
    for (int i = 0; i < 3 && i < t2c.size() - b2 && ok; i++) begin
      check($sformatf("casc_lag%0d", i), t2c[b2 + i], t1c[b1 + 2 * i + 1] + 1);
      check($sformatf("casc_addr%0d", i), t2a[b2 + i], i);
    end
    bus.reg_timer1_run = 1'b0; bus.reg_timer2_run = 1'b0;
    step(4);
`endif

    // Reset mid-count: counter restarts from a full interval afterwards.
    bus.reg_timer1_period = 12'd3; bus.reg_timer1_oneshot = 1'b0;
    bus.reg_timer1_run = 1'b1;
    step(6);
    nreset = 1'b0;
    #1;
    check("rst_mid_trig", int'(bus.timer1_trigger), 0);
    check("rst_mid_addr", int'(bus.timer1_address), 0);
    bus.reg_timer1_run = 1'b0;
    step(2);
    nreset = 1'b1;
    b1 = t1c.size();
    step(30);
    check("rst_idle_after", t1c.size() - b1, 0);
    bus.reg_timer1_run = 1'b1;
    k = cyc;
    wait_q1(b1 + 1, 40, ok);
    check("rst_rerun", int'(ok), 1);
    if (ok) begin
      check_range("rst_rerun_latency", t1c[b1] - (k + 1), 13, 16);
      check("rst_rerun_addr", t1a[b1], 0);
    end
    bus.reg_timer1_run = 1'b0;
    step(4);

    // Reset during a pulse with a non-zero index cancels it at once.
    bus.reg_timer1_period = 12'd0;
    bus.reg_timer1_run = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step(1);
      if (bus.timer1_trigger && bus.timer1_address == 2'd1) ok = 1'b1;
    end
    check("rst_pulse_found", int'(ok), 1);
    nreset = 1'b0;
    #1;
    check("rst_pulse_trig", int'(bus.timer1_trigger), 0);
    check("rst_pulse_addr", int'(bus.timer1_address), 0);
    bus.reg_timer1_run = 1'b0;
    step(2);
    nreset = 1'b1;
    b1 = t1c.size();
    step(20);
    check("rst_pulse_idle", t1c.size() - b1, 0);

    check("width1_ch1", consec1, 0);
    check("width1_ch2", consec2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
